// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back cache controller driving a cacheBlock tag/data RAM.
// Optional hit/miss counters are enabled with `define CACHE_PERF_CNT_EN.
module cache_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Cpu_Req,
  input  logic         Cpu_Wr,
  input  logic [31:0]  Cpu_Addr,
  input  logic [3:0]   Cpu_Byte_En,
  input  logic [31:0]  Cpu_Wdata,
  output logic [31:0]  Cpu_Rdata,
  output logic         Cpu_Ready,
  output logic         Init_Done,
  output logic         Mem_Req,
  output logic         Mem_Wr,
  output logic [31:0]  Mem_Addr,
  output logic [127:0] Mem_Wdata,
  input  logic [127:0] Mem_Rdata,
  input  logic         Mem_Ack,
  output logic [3:0]   En_Word,
  output logic [3:0]   En_Byte,
  output logic [9:0]   Index,
  output logic         Wr,
  output logic         ValidNew,
  output logic         DirtyNew,
  output logic [127:0] Data_In,
  output logic [17:0]  Tag_In,
  input  logic         Dirty_Out,
  input  logic         Valid_Out,
  input  logic [17:0]  Tag_Out,
  input  logic [127:0] Data_Out
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]  Hit_Cnt,
  output logic [31:0]  Miss_Cnt
`endif
);

  typedef enum logic [2:0] {
    StInit, StIdle, StLookup, StWriteback, StRefill, StUpdate, StReread
  } state_e;

  state_e       state_q, state_d;
  logic         init_go_q, init_go_d;
  logic [9:0]   cnt_q, cnt_d;
  logic         init_done_q, init_done_d;
  logic [31:0]  addr_q, addr_d;
  logic [3:0]   be_q, be_d;
  logic [31:0]  wdata_q, wdata_d;
  logic         wr_q, wr_d;
  logic [127:0] victim_q, victim_d;
  logic [17:0]  vtag_q, vtag_d;
  logic [127:0] line_q, line_d;

  logic [17:0]  tag;
  logic [9:0]   idx;
  logic         hit;

  assign tag = addr_q[31:14];
  assign idx = addr_q[13:4];
  assign hit = Valid_Out && (Tag_Out == tag);
  assign Init_Done = init_done_q;

  // Byte-enable patterns that are not an aligned byte, half or word fall back to the full word.
  function automatic logic [3:0] be_norm(input logic [3:0] be);
    case (be)
      4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000: return be;
      default: return 4'b1111;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    init_go_d   = init_go_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    victim_d    = victim_q;
    vtag_d      = vtag_q;
    line_d      = line_q;
    unique case (state_q)
      StInit: begin
        init_go_d = 1'b1;
        if (init_go_q) begin
          cnt_d = cnt_q + 10'd1;
          if (cnt_q == 10'd1023) begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      StIdle: begin
        if (Cpu_Req) begin
          addr_d  = Cpu_Addr;
          be_d    = Cpu_Byte_En;
          wdata_d = Cpu_Wdata;
          wr_d    = Cpu_Wr;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          state_d = StIdle;
        end else if (Valid_Out && Dirty_Out) begin
          victim_d = Data_Out;
          vtag_d   = Tag_Out;
          state_d  = StWriteback;
        end else begin
          state_d = StRefill;
        end
      end
      StWriteback: if (Mem_Ack) state_d = StRefill;
      StRefill: begin
        if (Mem_Ack) begin
          line_d  = Mem_Rdata;
          state_d = StUpdate;
        end
      end
      StUpdate: state_d = StReread;
      StReread: state_d = StLookup;
      default:  state_d = StInit;
    endcase
  end

  always_comb begin
    Cpu_Rdata = '0;
    Cpu_Ready = 1'b0;
    Mem_Req   = 1'b0;
    Mem_Wr    = 1'b0;
    Mem_Addr  = '0;
    Mem_Wdata = '0;
    En_Word   = '0;
    En_Byte   = '0;
    Index     = idx;
    Wr        = 1'b0;
    ValidNew  = 1'b0;
    DirtyNew  = 1'b0;
    Data_In   = '0;
    Tag_In    = '0;
    unique case (state_q)
      StInit: begin
        Index = cnt_q;
        if (init_go_q) begin
          Wr      = 1'b1;
          En_Word = 4'b1111;
          En_Byte = 4'b1111;
        end
      end
      // The RAM read is synchronous, so the index must be presented while the request is sampled.
      StIdle: Index = Cpu_Addr[13:4];
      StLookup: begin
        if (hit) begin
          Cpu_Ready = 1'b1;
          if (wr_q) begin
            Wr       = 1'b1;
            En_Word  = 4'b0001 << addr_q[3:2];
            En_Byte  = be_norm(be_q);
            Data_In  = {4{wdata_q}};
            Tag_In   = tag;
            ValidNew = 1'b1;
            DirtyNew = 1'b1;
          end else begin
            Cpu_Rdata = Data_Out[{addr_q[3:2], 5'b0} +: 32];
          end
        end
      end
      StWriteback: begin
        Mem_Req   = 1'b1;
        Mem_Wr    = 1'b1;
        Mem_Addr  = {vtag_q, idx, 4'b0000};
        Mem_Wdata = victim_q;
      end
      StRefill: begin
        Mem_Req  = 1'b1;
        Mem_Addr = {tag, idx, 4'b0000};
      end
      StUpdate: begin
        Wr       = 1'b1;
        En_Word  = 4'b1111;
        En_Byte  = 4'b1111;
        Data_In  = line_q;
        Tag_In   = tag;
        ValidNew = 1'b1;
      end
      StReread: Index = idx;
      default: Index = idx;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      init_go_q   <= 1'b0;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      victim_q    <= '0;
      vtag_q      <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_go_q   <= init_go_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      victim_q    <= victim_d;
      vtag_q      <= vtag_d;
      line_q      <= line_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic        reread_q, reread_d;
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // The LOOKUP that follows a refill re-resolves an already counted request.
  always_comb begin
    reread_d   = reread_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == StReread) reread_d = 1'b1;
    if (state_q == StIdle) reread_d = 1'b0;
    if (state_q == StLookup && !reread_q) begin
      if (hit) hit_cnt_d = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reread_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      reread_q   <= reread_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign Hit_Cnt  = hit_cnt_q;
  assign Miss_Cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: cacheBlock RAM and latency-programmable memory models, directed table,
// randomized requests against an abstract cache/memory model, and a reset-mid-refill sequence.
module tb_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Cpu_Req = 1'b0, Cpu_Wr = 1'b0;
  logic [31:0]  Cpu_Addr = '0, Cpu_Wdata = '0;
  logic [3:0]   Cpu_Byte_En = '0;
  logic [31:0]  Cpu_Rdata;
  logic         Cpu_Ready, Init_Done, Mem_Req, Mem_Wr;
  logic [31:0]  Mem_Addr;
  logic [127:0] Mem_Wdata;
  logic [127:0] Mem_Rdata = '0;
  logic         Mem_Ack = 1'b0;
  logic [3:0]   En_Word, En_Byte;
  logic [9:0]   Index;
  logic         Wr, ValidNew, DirtyNew;
  logic [127:0] Data_In;
  logic [17:0]  Tag_In;
  logic         Dirty_Out = 1'b0, Valid_Out = 1'b0;
  logic [17:0]  Tag_Out = '0;
  logic [127:0] Data_Out = '0;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]  Hit_Cnt, Miss_Cnt;
`endif

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .Cpu_Req(Cpu_Req), .Cpu_Wr(Cpu_Wr), .Cpu_Addr(Cpu_Addr), .Cpu_Byte_En(Cpu_Byte_En),
    .Cpu_Wdata(Cpu_Wdata), .Cpu_Rdata(Cpu_Rdata), .Cpu_Ready(Cpu_Ready), .Init_Done(Init_Done),
    .Mem_Req(Mem_Req), .Mem_Wr(Mem_Wr), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Rdata(Mem_Rdata), .Mem_Ack(Mem_Ack),
    .En_Word(En_Word), .En_Byte(En_Byte), .Index(Index), .Wr(Wr), .ValidNew(ValidNew),
    .DirtyNew(DirtyNew), .Data_In(Data_In), .Tag_In(Tag_In),
    .Dirty_Out(Dirty_Out), .Valid_Out(Valid_Out), .Tag_Out(Tag_Out), .Data_Out(Data_Out)
`ifdef CACHE_PERF_CNT_EN
    , .Hit_Cnt(Hit_Cnt), .Miss_Cnt(Miss_Cnt)
`endif
  );

  // cacheBlock: synchronous read, masked synchronous write.
  logic         cb_v [1024];
  logic         cb_dt[1024];
  logic [17:0]  cb_t [1024];
  logic [127:0] cb_d [1024];
  always @(posedge clk) begin
    Valid_Out <= cb_v[Index];
    Dirty_Out <= cb_dt[Index];
    Tag_Out   <= cb_t[Index];
    Data_Out  <= cb_d[Index];
    if (Wr) begin
      cb_v[Index]  <= ValidNew;
      cb_dt[Index] <= DirtyNew;
      cb_t[Index]  <= Tag_In;
      for (int w = 0; w < 4; w++)
        for (int b = 0; b < 4; b++)
          if (En_Word[w] && En_Byte[b]) cb_d[Index][w*32+b*8 +: 8] <= Data_In[w*32+b*8 +: 8];
    end
  end

  // Backing memory and responder.
  typedef struct { logic wr; logic [31:0] addr; logic [127:0] data; } txn_t;
  logic [127:0] bmem [logic [31:0]];
  txn_t         mem_log[$];
  int           mem_lat = 1;
  bit           mem_auto = 1'b1;

  function automatic logic [127:0] bmem_get(input logic [31:0] la);
    if (bmem.exists(la)) return bmem[la];
    return {la ^ 32'hC3C30003, la ^ 32'hB2B20002, la ^ 32'hA1A10001, la ^ 32'h90900000};
  endfunction

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      Mem_Ack = 1'b0;
      if (!rst_n) cnt = 0;
      else if (mem_auto && Mem_Req) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_log.push_back('{Mem_Wr, Mem_Addr, Mem_Wdata});
          if (Mem_Wr) bmem[Mem_Addr] = Mem_Wdata;
          else Mem_Rdata = bmem_get(Mem_Addr);
          Mem_Ack = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Abstract model: per-index resident line (valid/tag/dirty/words) over the backing memory.
  logic         mv [1024];
  logic         md [1024];
  logic [17:0]  mt [1024];
  logic [127:0] mdat[1024];
  int           m_hits = 0, m_misses = 0;

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  function automatic logic [3:0] legal_be(input logic [3:0] be);
    if (be inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000}) return be;
    return 4'b1111;
  endfunction

  task automatic do_req(input string nm, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        output logic hit_o, output logic [31:0] rdata_o, output logic wb_o,
                        output logic [31:0] wb_addr_o, output logic [127:0] wb_data_o,
                        output logic [3:0] ebyte_o);
    logic [9:0]   idx;
    logic [17:0]  tg;
    int           w, lat, exp_lat, exp_n, cyc;
    logic [31:0]  la, exp_rd;
    logic [3:0]   nbe;
    logic         m_hit, m_wb, got;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic         s_wr, s_dn, s_vn;
    logic [3:0]   s_ew, s_eb;
    logic [127:0] s_din;
    logic [17:0]  s_tin;
    idx = addr[13:4];
    tg  = addr[31:14];
    w   = int'(addr[3:2]);
    la  = {addr[31:4], 4'b0000};
    nbe = legal_be(be);
    m_hit   = mv[idx] && mt[idx] == tg;
    m_wb    = !m_hit && mv[idx] && md[idx];
    wb_addr = {mt[idx], idx, 4'b0000};
    wb_data = mdat[idx];
    lat     = $urandom_range(1, 4);
    exp_lat = m_hit ? 2 : (m_wb ? 2 * lat + 5 : lat + 5);
    exp_n   = m_hit ? 0 : (m_wb ? 2 : 1);
    if (m_hit) m_hits++;
    else m_misses++;
    if (!m_hit) begin
      mv[idx] = 1'b1;
      mt[idx] = tg;
      md[idx] = 1'b0;
      mdat[idx] = bmem_get(la);
    end
    exp_rd = mdat[idx][w*32 +: 32];
    if (wr) begin
      for (int b = 0; b < 4; b++) if (nbe[b]) mdat[idx][w*32+b*8 +: 8] = wdata[b*8 +: 8];
      md[idx] = 1'b1;
    end
    mem_log.delete();
    @(posedge clk);
    #1;
    mem_lat = lat;
    Cpu_Req = 1'b1;
    Cpu_Wr = wr;
    Cpu_Addr = addr;
    Cpu_Byte_En = be;
    Cpu_Wdata = wdata;
    cyc = 0;
    got = 1'b0;
    rdata_o = '0;
    {s_wr, s_dn, s_vn, s_ew, s_eb, s_din, s_tin} = '0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (Cpu_Ready === 1'b1) begin
        got = 1'b1;
        rdata_o = Cpu_Rdata;
        {s_wr, s_dn, s_vn, s_ew, s_eb, s_din, s_tin} =
            {Wr, DirtyNew, ValidNew, En_Word, En_Byte, Data_In, Tag_In};
      end
    end
    check({nm, " ready"}, got, 1'b1);
    check({nm, " latency"}, cyc, exp_lat);
    if (wr) begin
      check({nm, " st Wr"}, s_wr, 1'b1);
      check({nm, " st En_Word"}, s_ew, 4'b0001 << w);
      check({nm, " st En_Byte"}, s_eb, nbe);
      check({nm, " st Dirty/Valid"}, {s_dn, s_vn}, 2'b11);
      check({nm, " st Data_In"}, s_din, {4{wdata}});
      check({nm, " st Tag_In"}, s_tin, tg);
    end else begin
      check({nm, " ld Wr"}, s_wr, 1'b0);
      check({nm, " ld rdata"}, rdata_o, exp_rd);
    end
    check({nm, " mem txns"}, mem_log.size(), exp_n);
    if (mem_log.size() == exp_n && exp_n > 0) begin
      if (m_wb) check({nm, " wb"}, {mem_log[0].wr, mem_log[0].addr, mem_log[0].data},
                      {1'b1, wb_addr, wb_data});
      check({nm, " refill"}, {mem_log[exp_n-1].wr, mem_log[exp_n-1].addr}, {1'b0, la});
    end
    hit_o = (mem_log.size() == 0);
    wb_o = 1'b0;
    wb_addr_o = '0;
    wb_data_o = '0;
    if (mem_log.size() > 0 && mem_log[0].wr) begin
      wb_o = 1'b1;
      wb_addr_o = mem_log[0].addr;
      wb_data_o = mem_log[0].data;
    end
    ebyte_o = s_eb;
    @(posedge clk);
    #1;
    Cpu_Req = 1'b0;
    @(negedge clk);
    check({nm, " ready pulse"}, Cpu_Ready, 1'b0);
  endtask

  // Holds reset a few cycles, releases it, and follows the full invalidate sweep.
  task automatic do_init(input bit late_ack);
    int errs, k;
    repeat (3) begin
      @(negedge clk);
      check("reset outputs", {Mem_Req, Cpu_Ready, Init_Done, Wr, Index, En_Word, Mem_Addr},
            '0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    Cpu_Req = 1'b1;
    Cpu_Wr = 1'b0;
    Cpu_Addr = 32'h0000_1234;
    if (late_ack) begin
      fork
        begin
          @(posedge clk);
          #2;
          Mem_Rdata = '1;
          Mem_Ack = 1'b1;
        end
      join_none
    end
    k = 0;
    @(negedge clk);
    while (Wr !== 1'b1 && k < 4) begin
      @(negedge clk);
      k++;
    end
    check("init sweep start", Wr, 1'b1);
    errs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!(Wr === 1'b1 && Index === i[9:0] && ValidNew === 1'b0 && En_Word === 4'hF &&
            Init_Done === 1'b0 && Mem_Req === 1'b0 && Cpu_Ready === 1'b0)) errs++;
      if (i == 1020) Cpu_Req = 1'b0;
      @(negedge clk);
    end
    check("init sweep lines", errs, 0);
    check("init done", {Init_Done, Wr, Mem_Req}, 3'b100);
  endtask

  typedef struct {
    logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;
    logic exp_hit; logic [31:0] exp_rdata; logic exp_wb; logic [31:0] exp_wb_addr;
    logic [127:0] exp_wb_data; logic [3:0] exp_ebyte;
  } vec_t;

  initial begin
    vec_t vt[9];
    logic hit, wb;
    logic [31:0] rd, wba;
    logic [127:0] wbd;
    logic [3:0] eb;
    logic [17:0] rtags[4];
    logic [9:0]  ridx[4];
    logic [31:0] ra;
    bit got;
    vt[0] = '{0, 32'h1234, 4'hF, 0, 0, 32'h66665555, 0, 0, 0, 0};
    vt[1] = '{0, 32'h1234, 4'hF, 0, 1, 32'h66665555, 0, 0, 0, 0};
    vt[2] = '{1, 32'h1236, 4'b0100, 32'h00AB0000, 1, 0, 0, 0, 0, 4'b0100};
    vt[3] = '{0, 32'h1234, 4'hF, 0, 1, 32'h66AB5555, 0, 0, 0, 0};
    vt[4] = '{0, 32'h5230, 4'hF, 0, 0, 32'hCAFE0000, 1, 32'h1230,
              128'h44443333_22221111_66AB5555_88887777, 0};
    vt[5] = '{1, 32'h5238, 4'b1010, 32'h12345678, 1, 0, 0, 0, 0, 4'b1111};
    vt[6] = '{0, 32'h5238, 4'hF, 0, 1, 32'h12345678, 0, 0, 0, 0};
    vt[7] = '{1, 32'h9234, 4'b0001, 32'h000000EE, 0, 0, 1, 32'h5230,
              128'h55550003_12345678_55550001_CAFE0000, 4'b0001};
    vt[8] = '{0, 32'h9234, 4'hF, 0, 1, 32'h777777EE, 0, 0, 0, 0};
    bmem[32'h1230] = 128'h44443333_22221111_66665555_88887777;
    bmem[32'h5230] = 128'h55550003_55550002_55550001_CAFE0000;
    bmem[32'h9230] = 128'h99990003_99990002_77777777_99990000;
    model_reset();
    do_init(1'b0);

    for (int i = 0; i < 9; i++) begin
      do_req($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].be, vt[i].wdata,
             hit, rd, wb, wba, wbd, eb);
      check($sformatf("vec%0d hit", i), hit, vt[i].exp_hit);
      check($sformatf("vec%0d wb", i), wb, vt[i].exp_wb);
      if (!vt[i].wr) check($sformatf("vec%0d rdata", i), rd, vt[i].exp_rdata);
      else check($sformatf("vec%0d En_Byte", i), eb, vt[i].exp_ebyte);
      if (vt[i].exp_wb) check($sformatf("vec%0d wb line", i), {wba, wbd},
                              {vt[i].exp_wb_addr, vt[i].exp_wb_data});
    end

    rtags = '{18'd0, 18'd1, 18'd2, 18'h3FFFF};
    ridx  = '{10'h123, 10'h000, 10'h3FF, 10'h2A5};
    for (int i = 0; i < 120; i++) begin
      ra = {rtags[$urandom_range(0, 3)], ridx[$urandom_range(0, 3)], 4'($urandom)};
      do_req($sformatf("rnd%0d", i), 1'($urandom), ra, 4'($urandom), $urandom,
             hit, rd, wb, wba, wbd, eb);
    end
`ifdef CACHE_PERF_CNT_EN
    check("perf after random", {Hit_Cnt, Miss_Cnt}, {32'(m_hits), 32'(m_misses)});
`endif

    // Reset in the middle of a refill; the memory never answers before reset.
    mem_auto = 1'b0;
    @(posedge clk);
    #1;
    Cpu_Req = 1'b1;
    Cpu_Wr = 1'b0;
    Cpu_Addr = {18'd5, 10'h111, 4'h4};
    Cpu_Byte_En = 4'hF;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (Mem_Req === 1'b1) got = 1'b1;
    end
    check("mid refill Mem_Req", got, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset Mem_Req", {Mem_Req, Cpu_Ready, Wr}, 3'b000);
    Cpu_Req = 1'b0;
    mem_auto = 1'b1;
    model_reset();
    do_init(1'b1);

    do_req("post reset miss", 1'b0, 32'h1234, 4'hF, 0, hit, rd, wb, wba, wbd, eb);
    check("post reset invalidated", hit, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_req($sformatf("post reset hit%0d", i), 1'b0, 32'h1234, 4'hF, 0, hit, rd, wb, wba, wbd,
             eb);
      check($sformatf("post reset hit%0d flag", i), hit, 1'b1);
    end
`ifdef CACHE_PERF_CNT_EN
    check("perf miss count", Miss_Cnt, 32'(m_misses));
    check("perf hit count", Hit_Cnt, 32'(m_hits));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
